// File: rtl/tmr32_pwm_seq.sv
// Duty-cycle sequencer for the 32-bit timer/PWM block.
// Steps through a table of (cmpx, cmpy, repeat) entries and drives the
// timer's compare values and enable. It advances on each timer period
// boundary, which it detects as the rising edge of timeout_flag.
module tmr32_pwm_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int RPTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [AW-1:0]   cfg_addr,
    input  logic [31:0]     cfg_cmpx,
    input  logic [31:0]     cfg_cmpy,
    input  logic [RPTW-1:0] cfg_rpt,
    input  logic [AW-1:0]   seq_last,
    input  logic            seq_loop,
    input  logic            start,
    input  logic            stop,
    input  logic            timeout_flag,
    output logic            tmr_en,
    output logic [31:0]     cmpx,
    output logic [31:0]     cmpy,
    output logic [AW-1:0]   seq_idx,
    output logic            busy,
    output logic            step_pulse,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Sequence table (not reset; software loads it before use)
    logic [31:0]     r_tab_cmpx [DEPTH];
    logic [31:0]     r_tab_cmpy [DEPTH];
    logic [RPTW-1:0] r_tab_rpt  [DEPTH];

    state_t          r_state;
    logic            r_tf_q;
    logic [RPTW-1:0] r_rpt_cnt;
    logic            r_tmr_en;
    logic [31:0]     r_cmpx;
    logic [31:0]     r_cmpy;
    logic [AW-1:0]   r_seq_idx;
    logic            r_busy;
    logic            r_step_pulse;
    logic            r_done;

    logic            w_tf_rise;
    logic [AW-1:0]   w_next_idx;
    logic            w_at_last;

    assign w_tf_rise  = timeout_flag & ~r_tf_q;
    // The index wraps modulo DEPTH, because the width is AW bits.
    assign w_next_idx = r_seq_idx + {{(AW-1){1'b0}}, 1'b1};
    assign w_at_last  = (r_seq_idx == seq_last);

    assign tmr_en     = r_tmr_en;
    assign cmpx       = r_cmpx;
    assign cmpy       = r_cmpy;
    assign seq_idx    = r_seq_idx;
    assign busy       = r_busy;
    assign step_pulse = r_step_pulse;
    assign done       = r_done;

    // Table write port, usable in any state; the active outputs only pick up new data on reload
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_tab_cmpx[cfg_addr] <= cfg_cmpx;
            r_tab_cmpy[cfg_addr] <= cfg_cmpy;
            r_tab_rpt[cfg_addr]  <= cfg_rpt;
        end
    end

    // Delayed copy of timeout_flag for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tf_q <= 1'b0;
        end else begin
            r_tf_q <= timeout_flag;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rpt_cnt    <= {RPTW{1'b0}};
            r_tmr_en     <= 1'b0;
            r_cmpx       <= 32'd0;
            r_cmpy       <= 32'd0;
            r_seq_idx    <= {AW{1'b0}};
            r_busy       <= 1'b0;
            r_step_pulse <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_step_pulse <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmr_en <= 1'b0;
                    r_busy   <= 1'b0;
                    // stop has priority over start
                    if (start && !stop) begin
                        r_cmpx    <= r_tab_cmpx[0];
                        r_cmpy    <= r_tab_cmpy[0];
                        r_rpt_cnt <= r_tab_rpt[0];
                        r_seq_idx <= {AW{1'b0}};
                        r_busy    <= 1'b1;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    // One cycle with the enable low, so the timer sees a clean 0->1 edge.
                    // Any flag edge seen in this cycle is dropped.
                    if (stop) begin
                        r_tmr_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_tmr_en <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_tmr_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_tf_rise) begin
                        if (r_rpt_cnt != {RPTW{1'b0}}) begin
                            r_rpt_cnt <= r_rpt_cnt - {{(RPTW-1){1'b0}}, 1'b1};
                        end else if (!w_at_last) begin
                            r_seq_idx    <= w_next_idx;
                            r_cmpx       <= r_tab_cmpx[w_next_idx];
                            r_cmpy       <= r_tab_cmpy[w_next_idx];
                            r_rpt_cnt    <= r_tab_rpt[w_next_idx];
                            r_step_pulse <= 1'b1;
                        end else if (seq_loop) begin
                            r_seq_idx    <= {AW{1'b0}};
                            r_cmpx       <= r_tab_cmpx[0];
                            r_cmpy       <= r_tab_cmpy[0];
                            r_rpt_cnt    <= r_tab_rpt[0];
                            r_step_pulse <= 1'b1;
                        end else begin
                            // Natural end: the compare values hold their last setting
                            r_tmr_en <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_tmr_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_tmr_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_tmr_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmr32_pwm_seq.sv
// Directed testbench for tmr32_pwm_seq, with hand-computed expectations.
module tb_tmr32_pwm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_cmpx;
    logic [31:0] cfg_cmpy;
    logic [7:0]  cfg_rpt;
    logic [2:0]  seq_last;
    logic        seq_loop;
    logic        start;
    logic        stop;
    logic        timeout_flag;
    logic        tmr_en;
    logic [31:0] cmpx;
    logic [31:0] cmpy;
    logic [2:0]  seq_idx;
    logic        busy;
    logic        step_pulse;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    tmr32_pwm_seq #(.DEPTH(8), .AW(3), .RPTW(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_cmpx(cfg_cmpx), .cfg_cmpy(cfg_cmpy), .cfg_rpt(cfg_rpt),
        .seq_last(seq_last), .seq_loop(seq_loop), .start(start), .stop(stop),
        .timeout_flag(timeout_flag), .tmr_en(tmr_en), .cmpx(cmpx), .cmpy(cmpy),
        .seq_idx(seq_idx), .busy(busy), .step_pulse(step_pulse), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [31:0] x,
                               input logic [31:0] y, input logic [7:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_cmpx = x; cfg_cmpy = y; cfg_rpt = r;
        tick();
        cfg_we = 1'b0;
    endtask

    // Raise the flag for one edge (outputs after that edge are then visible)
    task automatic tf_rise_edge;
        timeout_flag = 1'b1;
        tick();
    endtask

    task automatic tf_low;
        timeout_flag = 1'b0;
        tick();
    endtask

    // Start pulse followed by the ARM cycle; ends in RUN
    task automatic start_seq;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic abort_seq;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_tests++; if (tmr_en !== 1'b0) begin n_fail++; $display("FAIL reset_tmr_en: got %b want 0", tmr_en); end
        n_tests++; if (cmpx !== 32'd0 || cmpy !== 32'd0) begin n_fail++; $display("FAIL reset_cmp: got %0d/%0d want 0/0", cmpx, cmpy); end
        n_tests++; if (seq_idx !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idx_busy: got %0d/%b want 0/0", seq_idx, busy); end
        n_tests++; if (step_pulse !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", step_pulse, done); end
        rst = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0 || tmr_en !== 1'b0) begin n_fail++; $display("FAIL reset_release: got busy=%b en=%b want 0/0", busy, tmr_en); end
    endtask

    task automatic test_single_pass;
        write_entry(3'd0, 32'd10, 32'd20, 8'd0);
        write_entry(3'd1, 32'd30, 32'd40, 8'd1);
        write_entry(3'd2, 32'd50, 32'd60, 8'd0);
        seq_last = 3'd2; seq_loop = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++; if (tmr_en !== 1'b0 || busy !== 1'b1 || cmpx !== 32'd10 || cmpy !== 32'd20) begin n_fail++; $display("FAIL sp_arm: got en=%b busy=%b cmpx=%0d cmpy=%0d want 0 1 10 20", tmr_en, busy, cmpx, cmpy); end
        tick();
        n_tests++; if (tmr_en !== 1'b1) begin n_fail++; $display("FAIL sp_en_rise: got %b want 1", tmr_en); end
        tf_rise_edge();
        n_tests++; if (cmpx !== 32'd30 || cmpy !== 32'd40 || seq_idx !== 3'd1 || step_pulse !== 1'b1) begin n_fail++; $display("FAIL sp_rise1: got cmpx=%0d cmpy=%0d idx=%0d step=%b want 30 40 1 1", cmpx, cmpy, seq_idx, step_pulse); end
        tf_low();
        n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL sp_step_width: got %b want 0", step_pulse); end
        tf_rise_edge();
        n_tests++; if (cmpx !== 32'd30 || seq_idx !== 3'd1 || step_pulse !== 1'b0) begin n_fail++; $display("FAIL sp_rise2_repeat: got cmpx=%0d idx=%0d step=%b want 30 1 0", cmpx, seq_idx, step_pulse); end
        tf_low();
        tf_rise_edge();
        n_tests++; if (cmpx !== 32'd50 || cmpy !== 32'd60 || seq_idx !== 3'd2 || step_pulse !== 1'b1) begin n_fail++; $display("FAIL sp_rise3: got cmpx=%0d cmpy=%0d idx=%0d step=%b want 50 60 2 1", cmpx, cmpy, seq_idx, step_pulse); end
        tf_low();
        tf_rise_edge();
        n_tests++; if (done !== 1'b1 || tmr_en !== 1'b0 || cmpx !== 32'd50) begin n_fail++; $display("FAIL sp_done: got done=%b en=%b cmpx=%0d want 1 0 50", done, tmr_en, cmpx); end
        tf_low();
        n_tests++; if (done !== 1'b0 || busy !== 1'b0 || tmr_en !== 1'b0) begin n_fail++; $display("FAIL sp_idle: got done=%b busy=%b en=%b want 0 0 0", done, busy, tmr_en); end
    endtask

    task automatic test_loop;
        logic [2:0] exp_idx [5];
        int steps;
        int done_seen;
        exp_idx[0] = 3'd1; exp_idx[1] = 3'd1; exp_idx[2] = 3'd2; exp_idx[3] = 3'd0; exp_idx[4] = 3'd1;
        steps = 0; done_seen = 0;
        seq_loop = 1'b1;
        start_seq();
        n_tests++; if (seq_idx !== 3'd0) begin n_fail++; $display("FAIL loop_idx_start: got %0d want 0", seq_idx); end
        for (int i = 0; i < 5; i++) begin
            tf_rise_edge();
            if (step_pulse === 1'b1) steps++;
            if (done === 1'b1) done_seen++;
            n_tests++; if (seq_idx !== exp_idx[i]) begin n_fail++; $display("FAIL loop_idx_%0d: got %0d want %0d", i, seq_idx, exp_idx[i]); end
            tf_low();
            if (step_pulse === 1'b1) steps++;
            if (done === 1'b1) done_seen++;
        end
        n_tests++; if (steps != 4) begin n_fail++; $display("FAIL loop_steps: got %0d want 4", steps); end
        n_tests++; if (done_seen != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL loop_no_done: got done_cnt=%0d busy=%b want 0 1", done_seen, busy); end
        abort_seq();
    endtask

    task automatic test_stop_start;
        start = 1'b1; stop = 1'b1;
        tick();
        n_tests++; if (busy !== 1'b0 || tmr_en !== 1'b0) begin n_fail++; $display("FAIL ss_idle_priority: got busy=%b en=%b want 0 0", busy, tmr_en); end
        start = 1'b0; stop = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ss_idle_hold: got busy=%b want 0", busy); end
        start_seq();
        tf_rise_edge();
        tf_low();
        n_tests++; if (seq_idx !== 3'd1 || cmpx !== 32'd30) begin n_fail++; $display("FAIL ss_at_idx1: got idx=%0d cmpx=%0d want 1 30", seq_idx, cmpx); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++; if (busy !== 1'b0 || tmr_en !== 1'b0 || cmpx !== 32'd30 || done !== 1'b0) begin n_fail++; $display("FAIL ss_stop_run: got busy=%b en=%b cmpx=%0d done=%b want 0 0 30 0", busy, tmr_en, cmpx, done); end
        tick();
        n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ss_no_done: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_flag_handling;
        start = 1'b1;
        tick();
        start = 1'b0;
        timeout_flag = 1'b1;
        tick();
        n_tests++; if (seq_idx !== 3'd0 || cmpx !== 32'd10 || step_pulse !== 1'b0 || tmr_en !== 1'b1) begin n_fail++; $display("FAIL flag_arm_ignored: got idx=%0d cmpx=%0d step=%b en=%b want 0 10 0 1", seq_idx, cmpx, step_pulse, tmr_en); end
        tf_low();
        n_tests++; if (seq_idx !== 3'd0) begin n_fail++; $display("FAIL flag_arm_after: got %0d want 0", seq_idx); end
        timeout_flag = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++; if (seq_idx !== 3'd1 || cmpx !== 32'd30) begin n_fail++; $display("FAIL flag_held_once: got idx=%0d cmpx=%0d want 1 30", seq_idx, cmpx); end
        tf_low();
        tf_rise_edge();
        tf_low();
        n_tests++; if (seq_idx !== 3'd1) begin n_fail++; $display("FAIL flag_repeat: got %0d want 1", seq_idx); end
        tf_rise_edge();
        n_tests++; if (seq_idx !== 3'd2 || step_pulse !== 1'b1) begin n_fail++; $display("FAIL flag_next_step: got idx=%0d step=%b want 2 1", seq_idx, step_pulse); end
        tf_low();
        abort_seq();
    endtask

    task automatic test_live_write;
        seq_last = 3'd2; seq_loop = 1'b1;
        start_seq();
        tf_rise_edge();
        tf_low();
        write_entry(3'd1, 32'd99, 32'd40, 8'd1);
        n_tests++; if (seq_idx !== 3'd1 || cmpx !== 32'd30) begin n_fail++; $display("FAIL lw_after_write: got idx=%0d cmpx=%0d want 1 30", seq_idx, cmpx); end
        tf_rise_edge();
        tf_low();
        n_tests++; if (cmpx !== 32'd30) begin n_fail++; $display("FAIL lw_repeat_hold: got %0d want 30", cmpx); end
        tf_rise_edge();
        tf_low();
        n_tests++; if (seq_idx !== 3'd2 || cmpx !== 32'd50) begin n_fail++; $display("FAIL lw_idx2: got idx=%0d cmpx=%0d want 2 50", seq_idx, cmpx); end
        tf_rise_edge();
        tf_low();
        n_tests++; if (seq_idx !== 3'd0 || cmpx !== 32'd10) begin n_fail++; $display("FAIL lw_wrap: got idx=%0d cmpx=%0d want 0 10", seq_idx, cmpx); end
        tf_rise_edge();
        n_tests++; if (seq_idx !== 3'd1 || cmpx !== 32'd99 || step_pulse !== 1'b1) begin n_fail++; $display("FAIL lw_reload: got idx=%0d cmpx=%0d step=%b want 1 99 1", seq_idx, cmpx, step_pulse); end
        tf_low();
        abort_seq();
    endtask

    task automatic test_back_to_back;
        seq_last = 3'd0; seq_loop = 1'b0;
        start = 1'b1;
        tick();
        tick();
        tick();
        n_tests++; if (busy !== 1'b1 || tmr_en !== 1'b1 || seq_idx !== 3'd0 || step_pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_held_start: got busy=%b en=%b idx=%0d step=%b want 1 1 0 0", busy, tmr_en, seq_idx, step_pulse); end
        tf_rise_edge();
        n_tests++; if (done !== 1'b1 || tmr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got done=%b en=%b want 1 0", done, tmr_en); end
        tf_low();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done); end
        tick();
        n_tests++; if (busy !== 1'b1 || tmr_en !== 1'b0) begin n_fail++; $display("FAIL b2b_restart: got busy=%b en=%b want 1 0", busy, tmr_en); end
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0 || tmr_en !== 1'b0 || cmpx !== 32'd0 || seq_idx !== 3'd0) begin n_fail++; $display("FAIL b2b_mid_reset: got busy=%b en=%b cmpx=%0d idx=%0d want 0 0 0 0", busy, tmr_en, cmpx, seq_idx); end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_cmpx = 32'd0; cfg_cmpy = 32'd0;
        cfg_rpt = 8'd0; seq_last = 3'd0; seq_loop = 1'b0; start = 1'b0; stop = 1'b0;
        timeout_flag = 1'b0;
        test_reset();
        test_single_pass();
        test_loop();
        test_stop_start();
        test_flag_handling();
        test_live_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
